// File: rtl/axis_rr_pkt_arbiter_if.sv
// AXI-Stream bundle shared by producers and consumers of the packet arbiter.
// tkeep is one bit per tdata byte.
interface axi_stream_inf #(
    parameter int DSIZE = 8,
    parameter int USIZE = 1
) (
    input logic aclk
);
    localparam int KSIZE = (DSIZE + 7) / 8;

    logic             axis_tvalid;
    logic             axis_tready;
    logic             axis_tlast;
    logic [DSIZE-1:0] axis_tdata;
    logic [USIZE-1:0] axis_tuser;
    logic [KSIZE-1:0] axis_tkeep;

    modport master (input aclk, axis_tready,
                    output axis_tvalid, axis_tdata, axis_tuser, axis_tkeep, axis_tlast);
    modport slaver (input aclk, axis_tvalid, axis_tdata, axis_tuser, axis_tkeep, axis_tlast,
                    output axis_tready);
endinterface

// File: rtl/axis_rr_pkt_arbiter.sv
// Packet-level round-robin merge of NUM AXI-Stream slaves onto one master.
// A grant is held from the first beat to tlast; priority rotates from the last grant.
module axis_rr_pkt_arbiter #(
    parameter int NUM   = 4,
    parameter int DSIZE = 8,
    parameter int USIZE = 1,
    localparam int GW    = (NUM > 1) ? $clog2(NUM) : 1,
    localparam int KSIZE = (DSIZE + 7) / 8
) (
    input  logic           clock,
    input  logic           rst_n,
    input  logic [NUM-1:0] port_en,
    axi_stream_inf.slaver  s_inf [NUM],
    axi_stream_inf.master  m_inf,
    output logic [GW-1:0]  cur_grant,
    output logic           busy,
    output logic [15:0]    pkt_cnt
);
    typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;
    state_t state;

    logic [NUM-1:0]            s_vld, s_last, req;
    logic [NUM-1:0][DSIZE-1:0] s_data;
    logic [NUM-1:0][USIZE-1:0] s_user;
    logic [NUM-1:0][KSIZE-1:0] s_keep;
    logic                      m_vld, eop, nxt_found;
    logic [GW-1:0]             nxt_idx;
    logic [GW:0]               sum;

    genvar i;
    generate
        for (i = 0; i < NUM; i++) begin : g_lane
            assign s_vld[i]  = s_inf[i].axis_tvalid;
            assign s_last[i] = s_inf[i].axis_tlast;
            assign s_data[i] = s_inf[i].axis_tdata;
            assign s_user[i] = s_inf[i].axis_tuser;
            assign s_keep[i] = s_inf[i].axis_tkeep;
            assign s_inf[i].axis_tready = (state == LOCK) && (cur_grant == GW'(i)) && m_inf.axis_tready;
        end
    endgenerate

    assign req   = s_vld & port_en;
    assign m_vld = (state == LOCK) && s_vld[cur_grant];
    assign eop   = m_vld && m_inf.axis_tready && s_last[cur_grant];

    assign m_inf.axis_tvalid = m_vld;
    assign m_inf.axis_tdata  = s_data[cur_grant];
    assign m_inf.axis_tuser  = s_user[cur_grant];
    assign m_inf.axis_tkeep  = s_keep[cur_grant];
    assign m_inf.axis_tlast  = s_last[cur_grant];

    // Search starts one past the last grant; wrap is explicit so non-power-of-two NUM works.
    always_comb begin
        nxt_found = 1'b0;
        nxt_idx   = cur_grant;
        sum       = '0;
        for (int k = 1; k <= NUM; k++) begin
            sum = {1'b0, cur_grant} + (GW+1)'(k);
            if (sum >= (GW+1)'(NUM))
                sum = sum - (GW+1)'(NUM);
            if (!nxt_found && req[GW'(sum)]) begin
                nxt_found = 1'b1;
                nxt_idx   = GW'(sum);
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            cur_grant <= GW'(NUM - 1);
            pkt_cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (nxt_found) begin
                    state     <= LOCK;
                    busy      <= 1'b1;
                    cur_grant <= nxt_idx;
                end
                LOCK: if (eop) begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    pkt_cnt <= pkt_cnt + 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_rr_pkt_arbiter.sv
// Directed and random checks of the packet arbiter against a transaction-level
// reference: per-slave beat queues plus a rotating-pointer grant model.
module tb_axis_rr_pkt_arbiter;
    localparam int NUM = 4, DSIZE = 8, USIZE = 1;

    typedef struct packed {logic [7:0] d; logic u; logic l;} beat_t;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    logic [NUM-1:0]       port_en, t_vld, t_last, t_user, t_rdy;
    logic [NUM-1:0][7:0]  t_data;
    logic                 m_rdy;
    logic [1:0]           cur_grant;
    logic                 busy;
    logic [15:0]          pkt_cnt;

    axi_stream_inf #(.DSIZE(DSIZE), .USIZE(USIZE)) s_inf [NUM] (.aclk(clock));
    axi_stream_inf #(.DSIZE(DSIZE), .USIZE(USIZE)) m_inf (.aclk(clock));

    genvar gi;
    generate
        for (gi = 0; gi < NUM; gi++) begin : g_src
            assign s_inf[gi].axis_tvalid = t_vld[gi];
            assign s_inf[gi].axis_tdata  = t_data[gi];
            assign s_inf[gi].axis_tuser  = t_user[gi];
            assign s_inf[gi].axis_tkeep  = 1'b1;
            assign s_inf[gi].axis_tlast  = t_last[gi];
            assign t_rdy[gi] = s_inf[gi].axis_tready;
        end
    endgenerate
    assign m_inf.axis_tready = m_rdy;

    axis_rr_pkt_arbiter #(.NUM(NUM), .DSIZE(DSIZE), .USIZE(USIZE)) dut (
        .clock(clock), .rst_n(rst_n), .port_en(port_en),
        .s_inf(s_inf), .m_inf(m_inf),
        .cur_grant(cur_grant), .busy(busy), .pkt_cnt(pkt_cnt)
    );

    int total = 0, bad = 0;
    int cyc = 0;
    beat_t srcq [NUM][$];
    bit    cur_v [NUM];
    int    hold [NUM];
    int    hs_cnt [NUM];
    int    gap_pct = 0;
    int    rdy_mode = 0, pidx = 0;
    bit    rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int    mg;
    bit    mlock;
    int    mcnt;
    int    comp[$], comp_cyc[$], beats[$], beat_cyc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic add_pkt(input int s, input int len, input int base, input bit rnd);
        beat_t b;
        for (int j = 0; j < len; j++) begin
            b.d = rnd ? 8'($urandom) : 8'(base + j);
            b.u = rnd ? 1'($urandom) : 1'b0;
            b.l = (j == len - 1);
            srcq[s].push_back(b);
        end
    endtask

    task automatic drive();
        for (int s = 0; s < NUM; s++) begin
            if (!cur_v[s] && srcq[s].size() > 0) begin
                if (hold[s] > 0) hold[s]--;
                else if ($urandom_range(99) >= gap_pct) cur_v[s] = 1'b1;
            end
            t_vld[s] = cur_v[s];
            if (srcq[s].size() > 0) begin
                t_data[s] = srcq[s][0].d; t_user[s] = srcq[s][0].u; t_last[s] = srcq[s][0].l;
            end else begin
                t_data[s] = 8'h00; t_user[s] = 1'b0; t_last[s] = 1'b0;
            end
        end
        if (rdy_mode == 1) m_rdy = 1'($urandom_range(1));
        else if (rdy_mode == 2) begin m_rdy = rdy_pat[pidx % 4]; pidx++; end
    endtask

    task automatic check();
        bit ev;
        ev = mlock && cur_v[mg];
        chk("m_tvalid", {31'b0, m_inf.axis_tvalid}, {31'b0, ev});
        for (int s = 0; s < NUM; s++)
            chk($sformatf("s%0d_tready", s), {31'b0, t_rdy[s]}, {31'b0, (mlock && s == mg && m_rdy)});
        if (ev) begin
            chk("m_tdata", {24'b0, m_inf.axis_tdata}, {24'b0, srcq[mg][0].d});
            chk("m_tuser", {31'b0, m_inf.axis_tuser}, {31'b0, srcq[mg][0].u});
            chk("m_tlast", {31'b0, m_inf.axis_tlast}, {31'b0, srcq[mg][0].l});
        end
        chk("busy", {31'b0, busy}, {31'b0, mlock});
        chk("cur_grant", {30'b0, cur_grant}, 32'(mg));
        chk("pkt_cnt", {16'b0, pkt_cnt}, 32'(mcnt));
        if (m_inf.axis_tvalid === 1'b1 && m_rdy) begin
            beats.push_back(int'(m_inf.axis_tdata)); beat_cyc.push_back(cyc);
            if (m_inf.axis_tlast === 1'b1) begin comp.push_back(int'(cur_grant)); comp_cyc.push_back(cyc); end
        end
    endtask

    task automatic model_step();
        bit last_hs, found;
        int j;
        last_hs = 0; found = 0;
        for (int s = 0; s < NUM; s++)
            if (cur_v[s] && mlock && s == mg && m_rdy) begin
                last_hs = srcq[s][0].l;
                void'(srcq[s].pop_front());
                cur_v[s] = 1'b0;
                hs_cnt[s]++;
            end
        if (!mlock) begin
            for (int k = 1; k <= NUM; k++) begin
                j = (mg + k) % NUM;
                if (!found && cur_v[j] && port_en[j]) begin found = 1; mg = j; mlock = 1; end
            end
        end else if (last_hs) begin
            mlock = 0;
            mcnt = (mcnt + 1) % 65536;
        end
    endtask

    task automatic tick();
        drive();
        #1 check();
        @(posedge clock);
        model_step();
        cyc++;
        @(negedge clock);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int s = 0; s < NUM; s++) begin
            srcq[s].delete(); cur_v[s] = 0; hold[s] = 0; hs_cnt[s] = 0;
        end
        t_vld = '0; t_last = '0; t_user = '0; t_data = '0;
        mg = NUM - 1; mlock = 0; mcnt = 0;
        comp.delete(); comp_cyc.delete(); beats.delete(); beat_cyc.delete();
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_grant", {30'b0, cur_grant}, 32'(NUM - 1));
        chk("rst_pkt_cnt", {16'b0, pkt_cnt}, 32'd0);
        chk("rst_m_tvalid", {31'b0, m_inf.axis_tvalid}, 32'd0);
        chk("rst_tready", {28'b0, t_rdy}, 32'd0);
        @(negedge clock); @(negedge clock);
        rst_n = 1'b1;
    endtask

    task automatic run_until(input string tag, input int n, input int budget);
        int b;
        b = 0;
        while (comp.size() < n && b < budget) begin tick(); b++; end
        chk({tag, "_done"}, 32'(comp.size() >= n), 32'd1);
    endtask

    initial begin
        int exp2[5] = '{0, 1, 2, 3, 0};
        int exp4[6] = '{0, 1, 3, 0, 1, 2};
        int start, b;
        port_en = '1; m_rdy = 1'b1;
        @(negedge clock);

        // single requester, slave 2
        do_reset();
        add_pkt(2, 4, 8'h10, 0);
        start = cyc;
        run_until("single", 1, 30);
        tick(); tick();
        chk("single_nbeats", 32'(beats.size()), 32'd4);
        for (int j = 0; j < 4 && j < beats.size(); j++) begin
            chk($sformatf("single_beat%0d", j), 32'(beats[j]), 32'(8'h10 + j));
            chk($sformatf("single_cyc%0d", j), 32'(beat_cyc[j]), 32'(start + 1 + j));
        end
        chk("single_pkt_cnt", {16'b0, pkt_cnt}, 32'd1);
        chk("single_grant", {30'b0, cur_grant}, 32'd2);
        chk("single_busy", {31'b0, busy}, 32'd0);

        // all four continuously valid, 2-beat packets
        do_reset();
        for (int s = 0; s < NUM; s++) begin add_pkt(s, 2, 16 * s, 0); add_pkt(s, 2, 16 * s + 8, 0); end
        run_until("rr", 5, 60);
        chk("rr_pkt_cnt", {16'b0, pkt_cnt}, 32'd5);
        for (int j = 0; j < 5 && j < comp.size(); j++) begin
            chk($sformatf("rr_order%0d", j), 32'(comp[j]), 32'(exp2[j]));
            if (j > 0) chk($sformatf("rr_spacing%0d", j), 32'(comp_cyc[j] - comp_cyc[j-1]), 32'd3);
        end

        // backpressure on a 3-beat packet from slave 1
        do_reset();
        add_pkt(1, 3, 8'h40, 0); add_pkt(2, 1, 8'h50, 0);
        rdy_mode = 2; pidx = 0;
        run_until("bp", 2, 60);
        rdy_mode = 0; m_rdy = 1'b1;
        for (int j = 0; j < 3 && j < beats.size(); j++)
            chk($sformatf("bp_beat%0d", j), 32'(beats[j]), 32'(8'h40 + j));
        chk("bp_order", (comp.size() > 1) ? 32'(comp[1]) : 32'hFFFF, 32'd2);

        // mask: slave 2 excluded, re-enabled mid-packet
        do_reset();
        port_en = 4'b1011;
        for (int s = 0; s < NUM; s++) for (int p = 0; p < 3; p++) add_pkt(s, 2, 16 * s + 2 * p, 0);
        run_until("mask_a", 3, 40);
        b = 0;
        while (!(mlock && mg == 0) && b < 10) begin tick(); b++; end
        tick();
        port_en = 4'b1111;
        run_until("mask_b", 6, 40);
        for (int j = 0; j < 6 && j < comp.size(); j++)
            chk($sformatf("mask_order%0d", j), 32'(comp[j]), 32'(exp4[j]));

        // lock persistence through a 3-cycle tvalid gap
        do_reset();
        add_pkt(0, 3, 8'h60, 0); add_pkt(1, 2, 8'h70, 0);
        b = 0;
        while (hs_cnt[0] < 1 && b < 10) begin tick(); b++; end
        hold[0] = 3;
        run_until("lock", 2, 40);
        chk("lock_first", (comp.size() > 0) ? 32'(comp[0]) : 32'hFFFF, 32'd0);
        chk("lock_second", (comp.size() > 1) ? 32'(comp[1]) : 32'hFFFF, 32'd1);

        // asynchronous reset in the middle of a packet
        do_reset();
        add_pkt(3, 4, 8'h80, 0);
        b = 0;
        while (hs_cnt[3] < 1 && b < 10) begin tick(); b++; end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_m_tvalid", {31'b0, m_inf.axis_tvalid}, 32'd0);
        chk("arst_tready", {28'b0, t_rdy}, 32'd0);
        do_reset();
        add_pkt(1, 1, 8'h91, 0); add_pkt(0, 1, 8'h90, 0);
        run_until("arst", 2, 20);
        chk("arst_first", (comp.size() > 0) ? 32'(comp[0]) : 32'hFFFF, 32'd0);
        chk("arst_second", (comp.size() > 1) ? 32'(comp[1]) : 32'hFFFF, 32'd1);

        // random traffic, random backpressure and masks
        do_reset();
        rdy_mode = 1; gap_pct = 30;
        for (int n = 0; n < 3000; n++) begin
            for (int s = 0; s < NUM; s++)
                if (srcq[s].size() < 3) add_pkt(s, $urandom_range(1, 4), 0, 1);
            if (n % 50 == 0) port_en = 4'($urandom_range(15));
            tick();
        end
        chk("rand_progress", 32'(mcnt > 100), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axis_rr_pkt_arbiter.md
Name: axis_rr_pkt_arbiter

Overview:
- Packet-level round-robin arbiter: merges NUM axi_stream_inf slave streams onto one axi_stream_inf master stream.
- Used when several producers (sdl_md/hdl_md-style sources) share one downstream stream consumer.
- Locks a grant for a whole packet (until tlast), then rotates priority.
- Provides a grant index, a busy flag and a packet counter for debug/status.

Parameters:
- NUM, 4, number of slave streams (2..16).
- DSIZE, 8, tdata width; must match all attached interfaces.
- USIZE, 1, tuser width; must match all attached interfaces.

Ports:
- clock  input  1  single system clock; also the aclk of every attached interface.
- rst_n  input  1  asynchronous active-low reset.
- port_en  input  NUM  per-slave enable mask; bit i=0 excludes slave i from arbitration.
- s_inf[NUM]  axi_stream_inf.slaver  DSIZE/USIZE  requester streams.
- m_inf  axi_stream_inf.master  DSIZE/USIZE  merged output stream.
- cur_grant  output  $clog2(NUM)  index of the granted (or last granted) slave.
- busy  output  1  high while a packet is locked.
- pkt_cnt  output  16  count of completed output packets; wraps 0xFFFF->0.

Behaviour:
- Reset (async assert, sync release on clock) clears all state:
  - state=IDLE, busy=0, cur_grant=NUM-1 (so slave 0 has first priority), pkt_cnt=0.
  - m_inf.axis_tvalid=0; all s_inf.axis_tready=0.
- FSM has two states, IDLE and LOCK.
- IDLE:
  - req[i] = s_inf[i].axis_tvalid & port_en[i].
  - If any req is high, pick the first i searching cur_grant+1, cur_grant+2, ... modulo NUM.
  - On that edge: cur_grant<=i, busy<=1, state<=LOCK.
  - If no req, stay in IDLE; cur_grant holds.
  - All s_inf tready=0 and m_inf tvalid=0 in IDLE.
- LOCK datapath is combinational, zero latency, with g=cur_grant:
  - m_inf tdata/tuser/tkeep/tlast = s_inf[g] fields.
  - m_inf tvalid = s_inf[g].tvalid.
  - s_inf[g].tready = m_inf.axis_tready; all other s_inf tready=0.
- LOCK exit: a handshake (tvalid & tready) with tlast=1 causes, on that edge:
  - state<=IDLE, busy<=0, pkt_cnt<=pkt_cnt+1.
  - cur_grant is retained and becomes the rotation pointer for the next arbitration.
- Handshake rules:
  - Never drop or duplicate a beat.
  - A stalled m_inf (tready=0) holds the granted slave stalled.
  - tvalid gaps from the granted slave do not release the lock.
- Throughput: one mandatory IDLE bubble cycle per packet. Single-beat packets (tlast on first beat) are legal and take 2 cycles minimum.
- port_en:
  - Sampled only in IDLE.
  - Clearing a bit during LOCK does not abort the current packet.
  - All bits 0 keeps the block in IDLE.
- Simultaneous events:
  - A new request arriving on the tlast-handshake cycle is arbitrated in the following IDLE cycle.
  - Slave tvalid changes in IDLE only affect the request vector for that cycle.
- Reset mid-packet:
  - Immediate return to IDLE with tvalid/tready low; the partial packet is abandoned.
  - Upstream and downstream are assumed to be reset by the same rst_n.
- cur_grant index arithmetic is modulo NUM; for NUM not a power of two, wrap explicitly (NUM-1 -> 0).

Test Plan:
- Single requester: slave 2 sends a 4-beat packet (0x10..0x13, tlast on 0x13), m_inf tready=1 -> m_inf carries 0x10..0x13 in consecutive cycles one cycle after tvalid rises; pkt_cnt=1; cur_grant=2; busy returns to 0.
- All four slaves continuously valid with 2-beat packets -> grant order 0,1,2,3,0 after reset; one IDLE cycle between packets; pkt_cnt=5 after five packets.
- Backpressure: m_inf tready toggles 1,0,0,1 during a 3-beat packet from slave 1 -> s_inf[1].tready mirrors tready exactly; beats appear once each, in order; no other slave sees tready=1.
- Mask: port_en=4'b1011, slaves 0..3 all valid -> slave 2 never granted; order 0,1,3,0; set port_en[2]=1 mid-packet -> slave 2 is granted at the next rotation that reaches it.
- Lock persistence: slave 0 drops tvalid for 3 cycles mid-packet while slave 1 is valid -> grant stays 0, m_inf tvalid=0 during the gap, slave 1 is served only after slave 0's tlast.
- Async reset: assert rst_n=0 mid-packet between clock edges -> busy, m_inf tvalid and all tready go low immediately; after release, cur_grant=NUM-1 and the first grant goes to slave 0.
